// File: rtl/calc_arb_pkg.sv
// Shared definitions for the calculator command arbiter.
// - Command word layout: {RW[28], Addr[27:20], Sel[19:16], InB[15:8], InA[7:0]}.
// - FSM state encoding.
// - unpackCmd: splits a raw command word into its named fields.
package calc_arb_pkg;

  localparam int unsigned CMD_W    = 29;
  localparam int unsigned RW_BIT   = 28;
  localparam int unsigned ADDR_LSB = 20;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned SEL_LSB  = 16;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned INB_LSB  = 8;
  localparam int unsigned INB_W    = 8;
  localparam int unsigned INA_LSB  = 0;
  localparam int unsigned INA_W    = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } arbStateT;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [INB_W-1:0]  inB;
    logic [INA_W-1:0]  inA;
  } calcCmdT;

  function automatic calcCmdT unpackCmd(input logic [CMD_W-1:0] cmd);
    calcCmdT c;
    c.rw   = cmd[RW_BIT];
    c.addr = cmd[ADDR_LSB +: ADDR_W];
    c.sel  = cmd[SEL_LSB +: SEL_W];
    c.inB  = cmd[INB_LSB +: INB_W];
    c.inA  = cmd[INA_LSB +: INA_W];
    return c;
  endfunction

endpackage

// File: rtl/calc_rr_pick.sv
// Combinational two-way round-robin pick.
// Ports:
//   Req0, Req1 : pending requests
//   LastGrant  : index of the requester served most recently
//   Grant      : index of the winner (meaningful only when Valid)
//   Valid      : at least one request is pending
module calc_rr_pick (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic Grant,
  output logic Valid
);

  always_comb begin
    Valid = Req0 | Req1;
    // On contention the requester not served last time wins.
    if (Req0 && Req1) begin
      Grant = ~LastGrant;
    end else begin
      Grant = Req1;
    end
  end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Shares the calculator's single command port between two host requesters.
// Round-robin grant, latched command fields, one-cycle ValidCmd strobe, then
// tracks CalcBusy to report Done or Err (timeout / CalcActive lost) to the owner.
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   Req0/Cmd0, Req1/Cmd1 : requester command interfaces
//   Ack*, Done*, Err*    : one-cycle status pulses per requester
//   Owner                : current or last granted requester
//   Calc*                : registered command fields and strobe to the calculator
//   CalcBusy, CalcActive : calculator status
module calc_cmd_arbiter
  import calc_arb_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [CMD_W-1:0] Cmd0,
  input  logic             Req1,
  input  logic [CMD_W-1:0] Cmd1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Done0,
  output logic             Done1,
  output logic             Err0,
  output logic             Err1,
  output logic             Owner,
  output logic [7:0]       CalcInA,
  output logic [7:0]       CalcInB,
  output logic [3:0]       CalcSel,
  output logic [7:0]       CalcAddr,
  output logic             CalcRW,
  output logic             CalcValidCmd,
  input  logic             CalcBusy,
  input  logic             CalcActive
);

  localparam logic [TO_W-1:0] TimeoutMax  = TO_W'(BUSY_TIMEOUT);
  // Last cycle allowed in a wait state: counter starts at 0 on entry.
  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(BUSY_TIMEOUT - 1);

  arbStateT        stateQ, stateD;
  logic [TO_W-1:0] toCntQ;
  logic            ownerQ;
  logic            lastGrantQ;
  calcCmdT         cmdQ;
  logic            doneQ, errQ;

  logic            pickGrant, pickValid;
  logic            grantEn, finDone, finErr;
  logic            timeoutHit, waiting;

  calc_rr_pick uPick (
    .Req0      (Req0),
    .Req1      (Req1),
    .LastGrant (lastGrantQ),
    .Grant     (pickGrant),
    .Valid     (pickValid)
  );

  assign waiting    = (stateQ == StWaitBusy) || (stateQ == StWaitDone);
  assign timeoutHit = (toCntQ >= TimeoutLast);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD  = stateQ;
    grantEn = 1'b0;
    finDone = 1'b0;
    finErr  = 1'b0;
    case (stateQ)
      StIdle: begin
        // The IDLE cycle carrying a Done/Err pulse never grants, so the next
        // strobe comes at the earliest two cycles after the pulse.
        if (CalcActive && pickValid && !(doneQ || errQ)) begin
          grantEn = 1'b1;
          stateD  = StIssue;
        end
      end
      StIssue: begin
        if (!CalcActive) begin
          finErr = 1'b1;
        end else begin
          stateD = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!CalcActive) begin
          finErr = 1'b1;
        end else if (CalcBusy) begin
          stateD = StWaitDone;
        end else if (timeoutHit) begin
          finErr = 1'b1;
        end
      end
      StWaitDone: begin
        if (!CalcActive) begin
          finErr = 1'b1;
        end else if (!CalcBusy) begin
          finDone = 1'b1;
        end else if (timeoutHit) begin
          finErr = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
    if (finDone || finErr) begin
      stateD = StIdle;
    end
  end

  // Timeout counter: restarts on every state change, saturates at the limit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      toCntQ <= '0;
    end else if (!waiting || (stateD != stateQ)) begin
      toCntQ <= '0;
    end else if (toCntQ < TimeoutMax) begin
      toCntQ <= toCntQ + 1'b1;
    end
  end

  // Grant bookkeeping, command latch and status pulse registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ownerQ     <= 1'b0;
      lastGrantQ <= 1'b1;
      cmdQ       <= '0;
      doneQ      <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      doneQ <= finDone;
      errQ  <= finErr;
      if (grantEn) begin
        ownerQ <= pickGrant;
        cmdQ   <= pickGrant ? unpackCmd(Cmd1) : unpackCmd(Cmd0);
      end
      if (finDone || finErr) begin
        lastGrantQ <= ownerQ;
      end
    end
  end

  // Outputs: all derived from registers; Owner is stable while pulses are shown.
  always_comb begin
    CalcValidCmd = (stateQ == StIssue);
    Ack0         = CalcValidCmd & ~ownerQ;
    Ack1         = CalcValidCmd &  ownerQ;
    Done0        = doneQ & ~ownerQ;
    Done1        = doneQ &  ownerQ;
    Err0         = errQ & ~ownerQ;
    Err1         = errQ &  ownerQ;
    Owner        = ownerQ;
    CalcInA      = cmdQ.inA;
    CalcInB      = cmdQ.inB;
    CalcSel      = cmdQ.sel;
    CalcAddr     = cmdQ.addr;
    CalcRW       = cmdQ.rw;
  end

endmodule

// File: doc/calc_cmd_arbiter.md
Name: calc_cmd_arbiter

Overview:
- Shares the binary calculator's single command port between two host requesters.
- Round-robin arbitration; latches the winning command and issues a one-cycle ValidCmd.
- Holds the command stable while the calculator is busy, then reports completion or error to the granted requester.
- Sits between the host interfaces and the calculator top (InA/InB/Sel/Addr/RW/ValidCmd inputs; CalcBusy/CalcActive outputs).

Parameters:
- BUSY_TIMEOUT, 255: maximum cycles spent in each wait state before an error is declared.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0  in  1  requester 0 command request.
- Cmd0  in  29  requester 0 command, packed {RW[28], Addr[27:20], Sel[19:16], InB[15:8], InA[7:0]}.
- Req1  in  1  requester 1 command request.
- Cmd1  in  29  requester 1 command, same packing as Cmd0.
- Ack0, Ack1  out  1 each  one-cycle pulse: command accepted and issued.
- Done0, Done1  out  1 each  one-cycle pulse: calculator finished the granted command.
- Err0, Err1  out  1 each  one-cycle pulse: timeout, or CalcActive lost, during the granted command.
- Owner  out  1  index of the current or last granted requester.
- CalcInA  out  8  registered command field.
- CalcInB  out  8  registered command field.
- CalcSel  out  4  registered command field.
- CalcAddr  out  8  registered command field.
- CalcRW  out  1  registered command field.
- CalcValidCmd  out  1  one-cycle command strobe to the calculator.
- CalcBusy  in  1  calculator busy indication.
- CalcActive  in  1  calculator active (InputKey enabled) indication.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Last-grant pointer = 1, so requester 0 wins the first contention.
  - Timeout counter = 0.
- Reset takes priority over all other events in every state. An operation in progress is dropped silently: no Done or Err pulse.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If CalcActive=1 and any Req is high, pick the winner.
  - One request: that requester wins.
  - Both requests: the requester that is not the last-grant pointer wins.
  - Latch the winner's Cmd into the Calc* registers, set Owner, go to ISSUE.
  - If CalcActive=0, requests are ignored.
- ISSUE (exactly 1 cycle):
  - CalcValidCmd=1 and Ack[Owner]=1.
  - Clear the timeout counter, go to WAIT_BUSY.
  - Latency: Req sampled high in cycle N gives CalcValidCmd and Ack in cycle N+1.
- WAIT_BUSY:
  - CalcBusy=1: clear the counter, go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: Err[Owner] pulse, go to IDLE.
- WAIT_DONE:
  - CalcBusy=0: Done[Owner] pulse, go to IDLE.
  - Counter reaches BUSY_TIMEOUT: Err[Owner] pulse, go to IDLE.
- Last-grant pointer is updated to Owner on every exit from WAIT_DONE or WAIT_BUSY, whether Done or Err.
- CalcActive falls in ISSUE, WAIT_BUSY or WAIT_DONE: Err[Owner] pulse next cycle, go to IDLE. This takes priority over Done and timeout in the same cycle.
- Calc* command registers:
  - Change only on the IDLE to ISSUE transition.
  - Hold their value through Done/Err and in IDLE until the next grant.
- Requester handshake:
  - Requester holds Req and Cmd stable until Ack.
  - After Ack it may change them freely.
  - Req still high after Done is treated as a new request; round-robin then favours the other requester if it is requesting.
- Timeout counter saturates at BUSY_TIMEOUT, so there is no wrap-around.
- Ack, Done and Err are mutually exclusive per cycle, and at most one requester is signalled per cycle.
- Back-to-back: after Done in cycle M, the earliest next CalcValidCmd is cycle M+2 (IDLE, then ISSUE).

Decomposition:
- Package calc_arb_pkg:
  - State encoding constants (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3).
  - Cmd field bit offsets and widths (RW_BIT=28, ADDR_LSB=20, SEL_LSB=16, INB_LSB=8, INA_LSB=0).
  - CMD_W=29.
- Sub-module calc_rr_pick: combinational two-way round-robin pick.
  - Inputs: Req0, Req1, LastGrant.
  - Outputs: Grant index and Valid.
- FSM, timeout counter and command registers stay in calc_cmd_arbiter.

Test Plan:
- Single request: CalcActive=1; Req0=1 with Cmd0={RW=1, Addr=8'h05, Sel=4'h2, InB=8'h03, InA=8'h07}; CalcBusy high 4 cycles after ValidCmd, then low. Expect: ValidCmd and Ack0 one cycle after Req0; Calc* = 07/03/2/05/1; Done0 one cycle after CalcBusy falls; Owner=0.
- Contention: Req0=Req1=1 held continuously, each op completed. Expect grants 0,1,0,1 and matching Ack/Done pulses alternating; no double grant.
- Busy never rises: BUSY_TIMEOUT=4, CalcBusy stuck 0 after ValidCmd. Expect Err0 pulse 4 cycles after entering WAIT_BUSY; no Done0; IDLE follows; the next grant goes to Req1 if it is pending.
- CalcActive drop: CalcActive falls while in WAIT_DONE. Expect Err pulse to the owner; no Done. With CalcActive=0 and Req1=1, expect no Ack1 until CalcActive returns to 1.
- Reset mid-op: Reset=1 for 1 cycle in WAIT_DONE. Expect all outputs 0 next cycle, no Done/Err, Owner=0; Req0 and Req1 both high afterwards gives the grant to requester 0.
